// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop synchronizer, oversampled start/data/(parity)/stop framing.
// Build with UART_RX_PARITY_EN defined to add one parity bit between data and stop.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Sample_Tick,
  input  logic                 Rx_In,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Framing_Err,
  output logic                 Parity_Err,
  output logic                 Busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_e;
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_e;
`endif

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_rdy_q, data_rdy_d;
  logic                 framing_err_q, framing_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q, parity_err_d;
  logic                 par_bad_q, par_bad_d;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      data_rdy_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= Rx_In;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      data_rdy_q    <= data_rdy_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
    end
  end
`endif

  // Sampling points are mid-bit: half a bit after the start edge, then every full bit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    data_rdy_d    = 1'b0;
    framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = 1'b0;
    par_bad_d     = par_bad_q;
`endif
    if (Sample_Tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d     = '0;
            par_bad_d = rx_s_q ^ (^shift_q) ^ PAR_SENSE;
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (!rx_s_q) begin
              framing_err_d = 1'b1;
              state_d       = BREAK_WAIT;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_d = 1'b1;
              state_d      = IDLE;
`endif
            end else begin
              rx_data_d  = shift_q;
              data_rdy_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BREAK_WAIT: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy        = (state_q != IDLE);
    Rx_Data     = rx_data_q;
    Data_Rdy    = data_rdy_q;
    Framing_Err = framing_err_q;
  end

`ifdef UART_RX_PARITY_EN
  assign Parity_Err = parity_err_q;
`else
  // Parity sense has no effect without a parity bit on the wire.
  logic unused_parity_sense;
  assign unused_parity_sense = PARITY_ODD[0];
  assign Parity_Err = 1'b0;
`endif

endmodule
